// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with a small valid/ready FSM.
// Single-cycle ops finish the cycle after acceptance. Defining
// ALU_MULDIV_EN adds iterative signed MULT/DIV (shift-add / restoring, one
// bit per cycle) and the architectural HI/LO registers. Without it those
// functs decode as illegal, and hi, lo and divzero are tied to zero.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         aluop,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [3:0]         alucontrol,
  output logic               illegal,
  output logic               divzero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_MFHI = 4'b0100;
  localparam logic [3:0] C_MFLO = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_SLL  = 4'b1101;
  localparam logic [3:0] C_SRL  = 4'b1110;
  localparam logic [3:0] C_PASS = 4'b1111;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] C_MULT = 4'b1000;
  localparam logic [3:0] C_DIV  = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [3:0]         alucontrol_q, alucontrol_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         dec_ctrl;
  logic               dec_ill;
  logic               dec_kill;
  logic [WIDTH-1:0]   alu_res;

  // Decode aluop/funct into the 4-bit control word and illegal/kill flags.
  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    dec_kill = 1'b0;
    case (aluop)
      3'b001: dec_ctrl = C_SUB;
      3'b011: dec_ctrl = C_AND;
      3'b100: dec_ctrl = C_OR;
      3'b101: dec_ctrl = C_SLT;
      3'b010: begin
        case (funct)
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b101010: dec_ctrl = C_SLT;
          6'b100111: dec_ctrl = C_NOR;
          6'b000000: dec_ctrl = C_SLL;
          6'b000010: dec_ctrl = C_SRL;
          6'b001000: dec_ctrl = C_PASS;
`ifdef ALU_MULDIV_EN
          6'b010000: dec_ctrl = C_MFHI;
          6'b010010: dec_ctrl = C_MFLO;
          6'b011000: dec_ctrl = C_MULT;
          6'b011010: dec_ctrl = C_DIV;
`else
          // HI/LO ops are unsupported here: flag illegal and force result 0
          6'b010000, 6'b010010, 6'b011000, 6'b011010: begin
            dec_ctrl = C_AND;
            dec_ill  = 1'b1;
            dec_kill = 1'b1;
          end
`endif
          default: begin
            dec_ctrl = C_AND;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: dec_ctrl = C_ADD;
    endcase
  end

  // Single-cycle datapath, selected by the decoded control word.
  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      C_ADD:  alu_res = a + b;
      C_SUB:  alu_res = a - b;
      C_AND:  alu_res = a & b;
      C_OR:   alu_res = a | b;
      C_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_NOR:  alu_res = ~(a | b);
      C_SLL:  alu_res = b << shamt;
      C_SRL:  alu_res = b >> shamt;
      C_PASS: alu_res = a;
      C_MFHI: alu_res = hi;
      C_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
    if (dec_kill) alu_res = '0;
  end

`ifdef ALU_MULDIV_EN
  // work_q holds {acc, multiplier} for MULT and {remainder, dividend} for DIV
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               is_muldiv;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // One iteration of each algorithm, plus the final sign correction applied
  // on the committing cycle.
  always_comb begin
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
    is_muldiv = (dec_ctrl == C_MULT) || (dec_ctrl == C_DIV);
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mb_q} : '0);
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    // remainder < |b| <= 2**(WIDTH-1), so the shifted value fits in WIDTH bits
    div_sh    = {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]};
    div_diff  = {1'b0, div_sh} - {1'b0, mb_q};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_sh, work_q[WIDTH-2:0], 1'b0};
    prod_fix = (sa_q ^ sb_q) ? -mul_next : mul_next;
    quo_fix  = (sa_q ^ sb_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fix  = sa_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;
`else
  assign hi      = '0;
  assign lo      = '0;
  assign divzero = 1'b0;
`endif

  // Next-state and register updates for the control FSM and datapath.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    alucontrol_d = alucontrol_q;
    illegal_d    = illegal_q;
`ifdef ALU_MULDIV_EN
    work_d    = work_q;
    mb_d      = mb_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (is_muldiv) begin
            work_d = {{WIDTH{1'b0}}, a_mag};
            mb_d   = b_mag;
            sa_d   = a[WIDTH-1];
            sb_d   = b[WIDTH-1];
            cnt_d  = '0;
            if (dec_ctrl == C_MULT) begin
              state_d = S_MUL;
            end else if (b == '0) begin
              // divide by zero finishes immediately with fixed HI/LO values
              alucontrol_d = C_DIV;
              illegal_d    = 1'b0;
              hi_d         = a;
              lo_d         = '1;
              result_d     = '1;
              divzero_d    = 1'b1;
              state_d      = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`endif
            alucontrol_d = dec_ctrl;
            illegal_d    = dec_ill;
            result_d     = alu_res;
            state_d      = S_DONE;
`ifdef ALU_MULDIV_EN
          end
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == '1) begin
          hi_d         = prod_fix[2*WIDTH-1:WIDTH];
          lo_d         = prod_fix[WIDTH-1:0];
          result_d     = prod_fix[WIDTH-1:0];
          alucontrol_d = C_MULT;
          illegal_d    = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == '1) begin
          hi_d         = rem_fix;
          lo_d         = quo_fix;
          result_d     = quo_fix;
          alucontrol_d = C_DIV;
          illegal_d    = 1'b0;
          divzero_d    = 1'b0;
          state_d      = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  // State registers; reset aborts any in-flight MULT/DIV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      result_q     <= '0;
      zero_q       <= 1'b1;
      alucontrol_q <= C_ADD;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      alucontrol_q <= alucontrol_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef ALU_MULDIV_EN
  // MULT/DIV working registers and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q    <= '0;
      mb_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      work_q    <= work_d;
      mb_q      <= mb_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign alucontrol = alucontrol_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit. Expected results come
// from a behavioural model using native arithmetic, queued at issue and
// popped when out_valid is seen. MULT/DIV scenarios run when ALU_MULDIV_EN
// is defined; otherwise the illegal-funct behaviour of those ops is checked.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  aluop = 3'b000;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alucontrol;
  logic        illegal;
  logic        divzero;
  logic [31:0] hi, lo;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero),
    .alucontrol(alucontrol), .illegal(illegal), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  ctrl;
    logic        ill;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        dz_m = 1'b0;

  // values observed when out_valid was seen
  logic [31:0] o_res, o_hi, o_lo;
  logic [3:0]  o_ctrl;
  logic        o_ill, o_dz, o_zero;
  int          o_lat, o_busy, o_early;

  function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh, input logic [31:0] ph,
                                 input logic [31:0] pl, input logic pdz);
    exp_t e;
    longint sx, sy;
    logic [63:0] p, q, r;
    e.hi = ph; e.lo = pl; e.dz = pdz; e.ill = 1'b0; e.lat = 1;
    e.ctrl = 4'b0010; e.res = x + y;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'b001: begin e.ctrl = 4'b0110; e.res = x - y; end
      3'b011: begin e.ctrl = 4'b0000; e.res = x & y; end
      3'b100: begin e.ctrl = 4'b0001; e.res = x | y; end
      3'b101: begin e.ctrl = 4'b0111; e.res = (sx < sy) ? 32'd1 : 32'd0; end
      3'b010: begin
        case (fn)
          6'b100000: begin e.ctrl = 4'b0010; e.res = x + y; end
          6'b100010: begin e.ctrl = 4'b0110; e.res = x - y; end
          6'b100100: begin e.ctrl = 4'b0000; e.res = x & y; end
          6'b100101: begin e.ctrl = 4'b0001; e.res = x | y; end
          6'b101010: begin e.ctrl = 4'b0111; e.res = (sx < sy) ? 32'd1 : 32'd0; end
          6'b100111: begin e.ctrl = 4'b1100; e.res = ~(x | y); end
          6'b000000: begin e.ctrl = 4'b1101; e.res = y << sh; end
          6'b000010: begin e.ctrl = 4'b1110; e.res = y >> sh; end
          6'b001000: begin e.ctrl = 4'b1111; e.res = x; end
`ifdef ALU_MULDIV_EN
          6'b010000: begin e.ctrl = 4'b0100; e.res = ph; end
          6'b010010: begin e.ctrl = 4'b0101; e.res = pl; end
          6'b011000: begin
            p = sx * sy;
            e.ctrl = 4'b1000; e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = 33;
          end
          6'b011010: begin
            e.ctrl = 4'b1001;
            if (y == 32'd0) begin
              e.hi = x; e.lo = 32'hFFFF_FFFF; e.res = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else begin
              q = sx / sy; r = sx % sy;
              e.hi = r[31:0]; e.lo = q[31:0]; e.res = q[31:0]; e.dz = 1'b0; e.lat = 33;
            end
          end
`else
          6'b010000, 6'b010010, 6'b011000, 6'b011010: begin
            e.ctrl = 4'b0000; e.ill = 1'b1; e.res = 32'd0;
          end
`endif
          default: begin e.ctrl = 4'b0000; e.ill = 1'b1; e.res = x & y; end
        endcase
      end
      default: begin e.ctrl = 4'b0010; e.res = x + y; end
    endcase
    return e;
  endfunction

  // Issue one op from IDLE (called #1 after a posedge), queue its expectation
  // and wait (bounded) for out_valid; leaves the DUT back in IDLE.
  task automatic drive_op(input logic [2:0] op, input logic [5:0] fn,
                          input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    exp_t e;
    logic [31:0] hp, lp;
    e = model(op, fn, x, y, sh, hi_m, lo_m, dz_m);
    hi_m = e.hi; lo_m = e.lo; dz_m = e.dz;
    sbq.push_back(e);
    hp = hi; lp = lo;
    aluop = op; funct = fn; a = x; b = y; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    o_lat = 0; o_busy = 0; o_early = 0;
    for (int c = 1; c <= 80; c++) begin
      if (!in_ready) o_busy++;
      if (out_valid) begin o_lat = c; break; end
      if (hi !== hp || lo !== lp) o_early++;
      @(posedge clk); #1;
    end
    o_res = result; o_zero = zero; o_ctrl = alucontrol; o_ill = illegal;
    o_dz = divzero; o_hi = hi; o_lo = lo;
    if (o_lat != 0) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    exp_t e;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else ; if (in_ready !== 1'b1 || out_valid !== 1'b0) errors++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    // first op right after release; illegal funct leaves distinct state
    drive_op(3'b010, 6'b111111, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_lat !== 1 || o_res !== e.res || o_ill !== 1'b1) begin
      errors++; $display("FAIL first_op: lat=%0d res=%h ill=%b want 1 %h 1", o_lat, o_res, o_ill, e.res);
    end
    #2 reset = 1'b1; #1;
    checks++; if (result !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL reset_result: result=%h zero=%b want 0/1", result, zero);
    end
    checks++; if (alucontrol !== 4'b0010 || illegal !== 1'b0 || divzero !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ctrl=%b ill=%b dz=%b want 0010/0/0", alucontrol, illegal, divzero);
    end
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h rdy=%b ov=%b want 0/0/1/0", hi, lo, in_ready, out_valid);
    end
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [8:0] tbl [16];
    logic [31:0] x, y, held;
    exp_t e;
    int k;
    tbl = '{{3'b000,6'd0}, {3'b001,6'd0}, {3'b011,6'd0}, {3'b100,6'd0},
            {3'b101,6'd0}, {3'b110,6'd0}, {3'b111,6'd0}, {3'b010,6'b100000},
            {3'b010,6'b100010}, {3'b010,6'b100100}, {3'b010,6'b100101}, {3'b010,6'b101010},
            {3'b010,6'b100111}, {3'b010,6'b000000}, {3'b010,6'b000010}, {3'b010,6'b001000}};
    // directed: 5 - 7, and a wrapping add that yields zero
    drive_op(3'b010, 6'b100010, 32'd5, 32'd7, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'hFFFF_FFFE || o_ctrl !== 4'b0110 || o_zero !== 1'b0 || o_lat !== 1) begin
      errors++; $display("FAIL sub_5_7: res=%h ctrl=%b zero=%b lat=%0d want fffffffe 0110 0 1", o_res, o_ctrl, o_zero, o_lat);
    end
    drive_op(3'b000, 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== e.res || o_zero !== 1'b1) begin
      errors++; $display("FAIL add_wrap: res=%h zero=%b want %h 1", o_res, o_zero, e.res);
    end
    for (int i = 0; i < 48; i++) begin
      k = i % 16;
      case ($urandom_range(0, 3))
        0: x = 32'd0;
        1: x = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        default: x = $urandom;
      endcase
      y = (i % 5 == 0) ? x : $urandom;
      drive_op(tbl[k][8:6], tbl[k][5:0], x, y, 5'($urandom_range(0, 31)));
      e = sbq.pop_front();
      checks++; if (o_res !== e.res || o_zero !== (e.res == 32'd0) || o_ctrl !== e.ctrl ||
                    o_ill !== e.ill || o_lat !== e.lat) begin
        errors++;
        $display("FAIL basic[%0d]: res=%h z=%b ctrl=%b ill=%b lat=%0d want %h %b %b %b %0d", i,
                 o_res, o_zero, o_ctrl, o_ill, o_lat, e.res, (e.res == 32'd0), e.ctrl, e.ill, e.lat);
      end
    end
    // outputs hold while idle
    held = e.res;
    repeat (3) @(posedge clk); #1;
    checks++; if (result !== held || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold: result=%h ov=%b want %h 0", result, out_valid, held);
    end
  endtask

  task automatic test_shift_slt;
    exp_t e;
    drive_op(3'b010, 6'b000000, 32'd0, 32'd1, 5'd31);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'h8000_0000 || o_ctrl !== 4'b1101) begin
      errors++; $display("FAIL sll31: res=%h ctrl=%b want 80000000 1101", o_res, o_ctrl);
    end
    drive_op(3'b010, 6'b000010, 32'd0, 32'h8000_0000, 5'd31);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'd1 || o_ctrl !== 4'b1110) begin
      errors++; $display("FAIL srl31: res=%h ctrl=%b want 00000001 1110", o_res, o_ctrl);
    end
    drive_op(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'd1 || o_res !== e.res || o_ctrl !== 4'b0111) begin
      errors++; $display("FAIL slt_neg: res=%h ctrl=%b want 00000001 0111", o_res, o_ctrl);
    end
    drive_op(3'b101, 6'd0, 32'd1, 32'hFFFF_FFFF, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'd0 || o_zero !== 1'b1) begin
      errors++; $display("FAIL slt_pos: res=%h zero=%b want 0 1", o_res, o_zero);
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    drive_op(3'b010, 6'b111111, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_ill !== 1'b1 || o_res !== 32'h0E0D_B0E0 || o_ctrl !== 4'b0000) begin
      errors++; $display("FAIL illegal_and: ill=%b res=%h ctrl=%b want 1 0e0db0e0 0000", o_ill, o_res, o_ctrl);
    end
    drive_op(3'b010, 6'b100100, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_ill !== 1'b0 || o_res !== e.res) begin
      errors++; $display("FAIL legal_clears: ill=%b res=%h want 0 %h", o_ill, o_res, e.res);
    end
`ifndef ALU_MULDIV_EN
    drive_op(3'b010, 6'b011000, 32'd6, 32'd7, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_ill !== 1'b1 || o_res !== 32'd0 || o_lat !== 1 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
      errors++; $display("FAIL mult_disabled: ill=%b res=%h lat=%0d hi=%h lo=%h want 1 0 1 0 0", o_ill, o_res, o_lat, o_hi, o_lo);
    end
    drive_op(3'b010, 6'b011010, 32'd9, 32'd0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_ill !== 1'b1 || o_res !== 32'd0 || o_dz !== 1'b0 || o_lat !== 1) begin
      errors++; $display("FAIL div_disabled: ill=%b res=%h dz=%b lat=%0d want 1 0 0 1", o_ill, o_res, o_dz, o_lat);
    end
`endif
  endtask

  task automatic test_muldiv;
`ifdef ALU_MULDIV_EN
    exp_t e;
    logic [31:0] x, y;
    drive_op(3'b010, 6'b011000, -32'sd3, 32'd7, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_lat !== 33 || o_busy !== 33 || o_early !== 0) begin
      errors++; $display("FAIL mult_timing: lat=%0d busy=%0d early=%0d want 33 33 0", o_lat, o_busy, o_early);
    end
    checks++; if (o_hi !== 32'hFFFF_FFFF || o_lo !== 32'hFFFF_FFEB || o_res !== 32'hFFFF_FFEB || o_ctrl !== 4'b1000) begin
      errors++; $display("FAIL mult_val: hi=%h lo=%h res=%h ctrl=%b want ffffffff ffffffeb ffffffeb 1000", o_hi, o_lo, o_res, o_ctrl);
    end
    drive_op(3'b010, 6'b010000, 32'd0, 32'd0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== 32'hFFFF_FFFF || o_lat !== 1) begin
      errors++; $display("FAIL mfhi: res=%h lat=%0d want ffffffff 1", o_res, o_lat);
    end
    drive_op(3'b010, 6'b011010, -32'sd7, 32'd2, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'hFFFF_FFFF || o_dz !== 1'b0 || o_lat !== 33) begin
      errors++; $display("FAIL div_m7_2: lo=%h hi=%h dz=%b lat=%0d want fffffffd ffffffff 0 33", o_lo, o_hi, o_dz, o_lat);
    end
    drive_op(3'b010, 6'b011010, 32'd9, 32'd0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_lat !== 1 || o_hi !== 32'd9 || o_lo !== 32'hFFFF_FFFF || o_dz !== 1'b1 || o_res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_zero: lat=%0d hi=%h lo=%h dz=%b res=%h want 1 9 ffffffff 1 ffffffff", o_lat, o_hi, o_lo, o_dz, o_res);
    end
    drive_op(3'b010, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_lo !== 32'h8000_0000 || o_hi !== 32'd0 || o_dz !== 1'b0) begin
      errors++; $display("FAIL div_ovf: lo=%h hi=%h dz=%b want 80000000 0 0", o_lo, o_hi, o_dz);
    end
    for (int i = 0; i < 8; i++) begin
      x = $urandom; y = (i == 3) ? 32'h8000_0000 : $urandom >> (i * 3);
      if (y == 32'd0) y = 32'd3;
      drive_op(3'b010, (i % 2 == 0) ? 6'b011000 : 6'b011010, x, y, 5'd0);
      e = sbq.pop_front();
      checks++; if (o_hi !== e.hi || o_lo !== e.lo || o_res !== e.res || o_lat !== e.lat ||
                    o_early !== 0 || o_zero !== (e.res == 32'd0)) begin
        errors++; $display("FAIL muldiv[%0d]: hi=%h lo=%h res=%h lat=%0d early=%0d want %h %h %h %0d 0",
                           i, o_hi, o_lo, o_res, o_lat, o_early, e.hi, e.lo, e.res, e.lat);
      end
    end
    drive_op(3'b010, 6'b010010, 32'd0, 32'd0, 5'd0);
    e = sbq.pop_front();
    checks++; if (o_res !== e.res || o_ctrl !== 4'b0101) begin
      errors++; $display("FAIL mflo: res=%h ctrl=%b want %h 0101", o_res, o_ctrl, e.res);
    end
`endif
  endtask

  task automatic test_abort;
`ifdef ALU_MULDIV_EN
    exp_t e;
    int ov = 0;
    aluop = 3'b010; funct = 6'b011000; a = -32'sd3; b = 32'd7; shamt = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) ov++;
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++; if (ov !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state: ov=%0d out_valid=%b rdy=%b want 0 0 1", ov, out_valid, in_ready);
    end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort_hilo: hi=%h lo=%h want 0 0", hi, lo);
    end
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    aluop = 3'b000; a = 32'd11; b = 32'd22;
    @(posedge clk); #1;
    reset = 1'b0;
    e = model(aluop, funct, a, b, shamt, hi_m, lo_m, dz_m);
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sbq.pop_front();
    checks++; if (out_valid !== 1'b1 || result !== e.res || hi !== 32'd0) begin
      errors++; $display("FAIL abort_next: ov=%b res=%h hi=%h want 1 %h 0", out_valid, result, hi, e.res);
    end
    @(posedge clk); #1;
`endif
  endtask

  // in_valid held across two ops: the DONE cycle must not accept.
  task automatic test_back_to_back;
    exp_t e;
    aluop = 3'b010; funct = 6'b100101; a = 32'h1200_0034; b = 32'h0056_0000; in_valid = 1'b1;
    e = model(aluop, funct, a, b, shamt, hi_m, lo_m, dz_m);
    sbq.push_back(e);
    @(posedge clk); #1;
    aluop = 3'b001; a = 32'd100; b = 32'd1;
    e = sbq.pop_front();
    checks++; if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first: ov=%b res=%h rdy=%b want 1 %h 0", out_valid, result, in_ready, e.res);
    end
    e = model(aluop, funct, a, b, shamt, hi_m, lo_m, dz_m);
    sbq.push_back(e);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h1256_0034) begin
      errors++; $display("FAIL b2b_gap: ov=%b rdy=%b res=%h want 0 1 12560034", out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sbq.pop_front();
    checks++; if (out_valid !== 1'b1 || result !== 32'd99 || alucontrol !== 4'b0110) begin
      errors++; $display("FAIL b2b_second: ov=%b res=%h ctrl=%b want 1 63 0110", out_valid, result, alucontrol);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift_slt();
    test_illegal();
    test_muldiv();
    test_abort();
    test_back_to_back();
    checks++; if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
